// File: rtl/inst_encoder_loader_if.sv
// Signal bundle between a program source and inst_encoder_loader: field-level encode
// requests in, instruction-memory write port and loader status out.
interface inst_encoder_loader_if;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic [15:0] words_written;
    logic [15:0] err_count;
    logic        full;
    logic [1:0]  dbg_state;

    modport slave (
        input  start, req_valid, req_kind, req_funct3, req_alt,
               req_rd, req_rs1, req_rs2, req_imm, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata,
               words_written, err_count, full, dbg_state
    );

    modport master (
        output start, req_valid, req_kind, req_funct3, req_alt,
               req_rd, req_rs1, req_rs2, req_imm, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata,
               words_written, err_count, full, dbg_state
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs field-level RV32I requests into instruction words and streams them into IMEM
// through a one-entry output register; illegal requests are dropped and counted.
module inst_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_encoder_loader_if.slave  bus
);
    // Handshake: a request transfers on a rising edge with req_valid & req_ready; a write
    // completes on an edge with imem_we & imem_ready, and imem_we/addr/wdata hold until then.

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] words_q, words_d;
    logic [15:0] err_q, err_d;

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;

    assign imm = bus.req_imm;
    assign rd  = bus.req_rd;
    assign rs1 = bus.req_rs1;
    assign rs2 = bus.req_rs2;
    assign f3  = bus.req_funct3;
    assign alt = bus.req_alt;

    // Range checks reduce to "all bits above the field are copies of its sign bit".
    logic i_ok, b_ok, j_ok, u_ok, sh_ok;

    always_comb begin
        i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
        b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
        j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
        u_ok  = ~(|imm[11:0]);
        sh_ok = ~(|imm[31:5]);
    end

    logic        legal;
    logic [31:0] word;

    always_comb begin
        legal = 1'b1;
        word  = 32'h0;
        case (bus.req_kind)
            4'd0: begin
                legal = u_ok;
                word  = {imm[31:12], rd, OP_LUI};
            end
            4'd1: begin
                legal = u_ok;
                word  = {imm[31:12], rd, OP_AUIPC};
            end
            4'd2: begin
                legal = j_ok;
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            4'd3: begin
                legal = i_ok & (f3 == 3'b000);
                word  = {imm[11:0], rs1, f3, rd, OP_JALR};
            end
            4'd4: begin
                legal = b_ok & (f3 != 3'b010) & (f3 != 3'b011);
                word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            end
            4'd5: begin
                legal = i_ok & (f3 != 3'b011) & (f3 != 3'b110) & (f3 != 3'b111);
                word  = {imm[11:0], rs1, f3, rd, OP_LOAD};
            end
            4'd6: begin
                legal = i_ok & (f3 <= 3'b010);
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            end
            4'd7: begin
                // Shifts carry a 5-bit shamt and SRAI's alt bit; other OPIMM ops are plain I-type.
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    legal = sh_ok & (~alt | (f3 == 3'b101));
                    word  = {1'b0, alt, 5'b00000, imm[4:0], rs1, f3, rd, OP_OPIMM};
                end else begin
                    legal = i_ok & ~alt;
                    word  = {imm[11:0], rs1, f3, rd, OP_OPIMM};
                end
            end
            4'd8: begin
                legal = ~alt | (f3 == 3'b000) | (f3 == 3'b101);
                word  = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, OP_OP};
            end
            4'd9: begin
                legal = i_ok;
                word  = {imm[11:0], rs1, f3, rd, OP_SYSTEM};
            end
            4'd10: begin
                legal = i_ok & (f3 <= 3'b001);
                word  = {imm[11:0], rs1, f3, rd, OP_FENCE};
            end
            default: begin
                legal = 1'b0;
                word  = 32'h0;
            end
        endcase
    end

    logic drain, last_slot, ready_c, accept;

    // The last slot stays reserved while its write is outstanding so FULL is reached exactly.
    always_comb begin
        drain     = we_q & bus.imem_ready;
        last_slot = we_q & ((words_q + 16'd1) == MAX_W);
        ready_c   = (state_q == RUN) & (~we_q | bus.imem_ready) & ~last_slot;
        accept    = bus.req_valid & ready_c;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        words_d = words_q;
        err_d   = err_q;
        if (bus.start) begin
            state_d = RUN;
            we_d    = 1'b0;
            addr_d  = BASE_ADDR;
            wdata_d = 32'h0;
            words_d = 16'h0;
            err_d   = 16'h0;
        end else if (state_q == RUN) begin
            if (drain) begin
                we_d    = 1'b0;
                addr_d  = addr_q + 32'd4;
                words_d = words_q + 16'd1;
                if (last_slot) begin
                    state_d = FULL;
                end
            end
            if (accept) begin
                if (legal) begin
                    we_d    = 1'b1;
                    wdata_d = word;
                end else if (err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            words_q <= 16'h0;
            err_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.imem_we       = we_q;
    assign bus.imem_addr     = addr_q;
    assign bus.imem_wdata    = wdata_q;
    assign bus.words_written = words_q;
    assign bus.err_count     = err_q;
    assign bus.full          = (state_q == FULL);
    assign bus.dbg_state     = state_q;
endmodule
